// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between NUM_MST masters, one
// transaction at a time, with a watchdog that forces completion of hung accesses.
//
// state | meaning
// IDLE  | no transaction in flight, arbitrate pending requests
// ISSUE | one-cycle read or write strobe to the peripheral bus
// WAIT  | waiting for i_peri_ready, watchdog running
// RESP  | ready pulse and response word to the granted master
module peri_bus_arbiter #(
  parameter int          NUM_MST     = 2,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_MST-1:0]     i_m_rden,
  input  logic [NUM_MST-1:0]     i_m_wren,
  input  logic [NUM_MST*32-1:0]  i_m_addr,
  input  logic [NUM_MST*32-1:0]  i_m_wdata,
  input  logic [NUM_MST*4-1:0]   i_m_wstrb,
  output logic [31:0]            o_m_rdata,
  output logic [NUM_MST-1:0]     o_m_ready,
  output logic                   o_peri_rden,
  output logic                   o_peri_wren,
  output logic [31:0]            o_peri_addr,
  output logic [31:0]            o_peri_wdata,
  output logic [3:0]             o_peri_wstrb,
  input  logic [31:0]            i_peri_rdata,
  input  logic                   i_peri_ready,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic [15:0]            o_timeout_cnt
);

  localparam int GW = $clog2(NUM_MST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_MST-1:0] req;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      pick;
  logic               op_wr;
  logic [15:0]        wd_cnt;
  logic               peri_hit;
  logic               wd_fire;
  logic [31:0]        m_addr  [NUM_MST];
  logic [31:0]        m_wdata [NUM_MST];
  logic [3:0]         m_wstrb [NUM_MST];

  assign req      = i_m_rden | i_m_wren;
  assign peri_hit = (state == S_WAIT) && i_peri_ready;
  // A ready arriving in the last watchdog cycle takes precedence over the timeout.
  assign wd_fire  = (state == S_WAIT) && !i_peri_ready && (wd_cnt == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    for (int k = 0; k < NUM_MST; k++) begin
      m_addr[k]  = i_m_addr[32*k +: 32];
      m_wdata[k] = i_m_wdata[32*k +: 32];
      m_wstrb[k] = i_m_wstrb[4*k +: 4];
    end
  end

  // Walk from farthest to nearest so the first requester after last_grant wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = last_grant;
    for (int k = NUM_MST; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (req[idx[GW-1:0]]) pick = idx[GW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (peri_hit || wd_fire) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_peri_rden = 1'b0;
    o_peri_wren = 1'b0;
    o_m_ready   = '0;
    o_busy      = (state != S_IDLE);
    case (state)
      S_ISSUE: begin
        o_peri_rden = !op_wr;
        o_peri_wren = op_wr;
      end
      S_RESP:  o_m_ready[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant    <= GW'(NUM_MST - 1);
      grant         <= '0;
      op_wr         <= 1'b0;
      o_peri_addr   <= '0;
      o_peri_wdata  <= '0;
      o_peri_wstrb  <= '0;
      wd_cnt        <= '0;
      o_m_rdata     <= '0;
      o_timeout     <= 1'b0;
      o_timeout_cnt <= '0;
    end else begin
      o_timeout <= wd_fire;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant        <= pick;
            op_wr        <= i_m_wren[pick];
            o_peri_addr  <= m_addr[pick];
            o_peri_wdata <= m_wdata[pick];
            o_peri_wstrb <= m_wstrb[pick];
          end
        end
        S_ISSUE: wd_cnt <= '0;
        S_WAIT: begin
          if (peri_hit) begin
            o_m_rdata <= i_peri_rdata;
          end else if (wd_fire) begin
            o_m_rdata <= ERR_DATA;
            if (o_timeout_cnt != 16'hFFFF) o_timeout_cnt <= o_timeout_cnt + 16'd1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RESP:  last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/peri_bus_arbiter.md
Name: peri_bus_arbiter

Overview:
- Shares the single peripheral bus (UART, CSR/timer, DMA, DRA slaves behind the peripheral bus decoder) between NUM_MST requesters, e.g. both issue slots of the two-issue pipeline plus a debug port.
- Round-robin arbitration; one outstanding transaction at a time.
- Guarantees every request completes: a watchdog terminates hung slave accesses with an error word and an error pulse.

Parameters:
- NUM_MST, 2, number of requesting masters (2..8).
- TIMEOUT_CYC, 255, WAIT cycles without i_peri_ready before forced completion (2..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- i_clk  in  1  single clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_m_rden  in  NUM_MST  per-master read request, level, held until that master's o_m_ready.
- i_m_wren  in  NUM_MST  per-master write request, level, held until o_m_ready.
- i_m_addr  in  NUM_MST*32  packed addresses, master k at [32k+31:32k].
- i_m_wdata  in  NUM_MST*32  packed write data.
- i_m_wstrb  in  NUM_MST*4  packed byte strobes.
- o_m_rdata  out  32  response data, shared, valid with any o_m_ready bit.
- o_m_ready  out  NUM_MST  one-cycle completion pulse, one-hot or zero.
- o_peri_rden  out  1  one-cycle read strobe to peripheral bus.
- o_peri_wren  out  1  one-cycle write strobe.
- o_peri_addr  out  32  registered address.
- o_peri_wdata  out  32  registered write data.
- o_peri_wstrb  out  4  registered strobes.
- i_peri_rdata  in  32  slave read data, valid with i_peri_ready.
- i_peri_ready  in  1  slave completion pulse.
- o_busy  out  1  high in any state except IDLE.
- o_timeout  out  1  one-cycle pulse on forced completion.
- o_timeout_cnt  out  16  saturating count of timeouts.

Behaviour:
- Reset values:
  - All outputs 0, o_m_rdata 0, o_timeout_cnt 0.
  - State IDLE; last-grant pointer = NUM_MST-1, so master 0 has first priority.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req[k] = i_m_rden[k] | i_m_wren[k].
  - If any req, grant the first set bit searching last_grant+1, +2, … modulo NUM_MST.
  - Latch grant index, addr, wdata, wstrb and op into registers; go ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - Assert exactly one of o_peri_rden/o_peri_wren for one cycle.
  - If a master drives rden and wren together, treat it as a write.
  - o_peri_addr/wdata/wstrb hold the latched values from ISSUE through RESP and change only at the next grant.
  - Clear the watchdog counter; go WAIT.
- WAIT:
  - i_peri_ready is sampled only here; ready in any other state is ignored.
  - On i_peri_ready: capture i_peri_rdata (captured for writes too) and go RESP.
  - Otherwise increment the 16-bit counter. When counter == TIMEOUT_CYC-1 with no ready, capture ERR_DATA, pulse o_timeout, saturating-increment o_timeout_cnt, and go RESP.
  - If ready and the timeout fire in the same cycle, ready wins: no timeout is recorded.
- RESP:
  - o_m_ready[grant]=1 for one cycle; o_m_rdata = captured word.
  - last_grant <= grant; go IDLE.
  - o_m_rdata holds its value until the next RESP.
- Handshake rules:
  - A master deasserts its request in the cycle after its o_m_ready, or holds it to issue a back-to-back transaction.
  - Requests are not sampled during RESP.
  - Minimum occupancy is 4 cycles per transaction with a 1-cycle slave.
  - Grant-to-strobe latency is 1 cycle.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,NUM_MST-1,0. No master waits more than NUM_MST-1 transactions.
- Request withdrawal: a request dropped after it was latched still completes; its ready pulse is still emitted.
- Late slave response: a ready arriving after timeout, outside WAIT, is discarded. System TIMEOUT_CYC must exceed the worst-case slave latency.
- Reset mid-transaction: return to IDLE next edge with no ready pulse and all strobes low. The outstanding slave response is dropped.

Test Plan:
- Single read: master 0 rden, addr 0x1000_0004; slave ready 2 cycles after strobe with 0x0000_00A5 -> one rden pulse at addr 0x1000_0004; o_m_ready=2'b01 for one cycle; o_m_rdata=0x0000_00A5.
- Round-robin: both masters hold requests for 4 transactions, 1-cycle slave -> grant order 0,1,0,1; each strobe 4 cycles apart; o_m_ready alternates 01,10,01,10.
- Timeout: TIMEOUT_CYC=8; master 1 reads; slave never answers -> ready 8 cycles after WAIT entry; o_m_ready=2'b10; o_m_rdata=0xDEAD_BEEF; o_timeout pulse; o_timeout_cnt=1.
- Ready at the timeout cycle: ready asserted with 0x1234_5678 at the 8th WAIT cycle -> o_m_rdata=0x1234_5678, no o_timeout, count unchanged.
- Write with both enables: master 0 drives rden=wren=1, wstrb 4'b0011, wdata 0xCAFE_0001 -> only o_peri_wren pulses; wstrb and wdata propagated unchanged.
- Reset in WAIT: assert i_rst for 1 cycle -> next cycle all outputs 0, o_busy=0, no o_m_ready; a following master-1 request is granted after master 0 per the reset pointer.
